// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin front end for the SDRAM core control port.
// One transaction is outstanding at a time. Each completion or timeout is
// returned to the client that owns the transaction as a registered pulse.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // client 0
    input  logic              c0_req,
    input  logic              c0_rd,
    input  logic [BE_W-1:0]   c0_wr,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_rvalid,
    output logic              c0_wvalid,
    output logic              c0_err,
    // client 1
    input  logic              c1_req,
    input  logic              c1_rd,
    input  logic [BE_W-1:0]   c1_wr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    output logic              c1_wvalid,
    output logic              c1_err,
    // SDRAM core control port
    output logic              mem_rd,
    output logic [BE_W-1:0]   mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic              mem_rvalid,
    input  logic              mem_wvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                rd_q, rd_d;
    logic [BE_W-1:0]     wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [1:0]          wvalid_q, wvalid_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic valid0, valid1, grant_any, win, mem_accept;

    // A request without rd or any byte enable is not a transaction.
    assign valid0    = c0_req & (c0_rd | (|c0_wr));
    assign valid1    = c1_req & (c1_rd | (|c1_wr));
    assign grant_any = (state_q == StIdle) & (valid0 | valid1);
    // On a tie the port that did not own the previous transaction wins.
    assign win       = (valid0 & valid1) ? ~last_owner_q : valid1;

    // Grant pulses are combinational; held low while reset is asserted.
    assign c0_gnt = grant_any & ~win & ~rst;
    assign c1_gnt = grant_any & win & ~rst;

    assign mem_rd     = (state_q == StIssue) & rd_q;
    assign mem_wr     = (state_q == StIssue) ? wr_q : '0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_accept = mem_rdy & (mem_rd | (|mem_wr));

    assign c0_rvalid = rvalid_q[0];
    assign c1_rvalid = rvalid_q[1];
    assign c0_wvalid = wvalid_q[0];
    assign c1_wvalid = wvalid_q[1];
    assign c0_err    = err_q[0];
    assign c1_err    = err_q[1];
    assign c0_rdata  = rdata0_q;
    assign c1_rdata  = rdata1_q;

    // Next-state: arbitration, capture, issue handshake and completion routing.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rvalid_d     = '0;
        wvalid_d     = '0;
        err_d        = '0;
        rdata0_d     = '0;
        rdata1_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    owner_d      = win;
                    last_owner_d = win;
                    rd_d         = win ? c1_rd : c0_rd;
                    // A read with byte enables set is issued as a pure read.
                    wr_d         = rd_d ? '0 : (win ? c1_wr : c0_wr);
                    addr_d       = win ? c1_addr : c0_addr;
                    wdata_d      = win ? c1_wdata : c0_wdata;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                // Core busy (e.g. refresh) just stalls here; no timeout applies.
                if (mem_accept) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion arriving on the timeout cycle takes priority.
                if (mem_rvalid) begin
                    state_d           = StIdle;
                    rvalid_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end else if (mem_wvalid) begin
                    state_d           = StIdle;
                    wvalid_d[owner_q] = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = StIdle;
                    err_d[owner_q] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rvalid_q     <= '0;
            wvalid_q     <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rvalid_q     <= rvalid_d;
            wvalid_q     <= wvalid_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule
